// File: rtl/parking_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : parking_slot_arbiter_if
//  Description : Request/release/grant bundle between the entry gates and the
//                parking slot arbiter. The master side issues entry requests
//                and slot releases. The slave side (the arbiter) returns the
//                grant, the assigned slot, the gate enables and the occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface parking_slot_arbiter_if;

    logic [1:0] req;            // level entry requests, bit per gate
    logic       release_valid;  // one-cycle strobe: a slot has been vacated
    logic [2:0] release_id;     // slot being vacated
    logic [1:0] grant;          // one-hot, one-cycle grant
    logic [2:0] slot_id;        // slot assigned with the grant
    logic [1:0] gate_open;      // one-hot gate motor enable
    logic [4:0] slot_busy;      // registered occupancy map
    logic [2:0] occupied;       // population count of slot_busy
    logic       full;           // every slot occupied

    modport master (
        output req, release_valid, release_id,
        input  grant, slot_id, gate_open, slot_busy, occupied, full
    );

    modport slave (
        input  req, release_valid, release_id,
        output grant, slot_id, gate_open, slot_busy, occupied, full
    );

endinterface
`default_nettype wire

// File: rtl/parking_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : parking_slot_arbiter
//  Description : Two-gate, five-slot car park arbiter. In IDLE the arbiter
//                samples the entry requests. When a slot is free, it picks a
//                gate round-robin and assigns the lowest free slot. It then
//                issues a one-cycle grant and holds that gate open for
//                GATE_OPEN_CYCLES cycles. A slot release is accepted in any
//                state.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_arbiter #(
    parameter int GATE_OPEN_CYCLES = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    parking_slot_arbiter_if.slave   bus
);

    localparam int       c_NUM_SLOTS = 5;
    localparam logic [7:0] c_OPEN_LAST = 8'(GATE_OPEN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OPEN  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [4:0] r_slot_busy;
    logic       r_winner;       // gate granted by the current transaction
    logic       r_prio;         // gate that wins when both gates request
    logic [2:0] r_slot_id;      // slot assigned by the current transaction
    logic [7:0] r_open_cnt;     // open cycles left after the current one

    logic       w_full;
    logic       w_start;
    logic       w_winner;
    logic [2:0] w_free_idx;
    logic [4:0] w_rel_mask;
    logic [4:0] w_alloc_mask;
    logic [4:0] w_busy_next;
    logic [2:0] w_occupied;
    logic [1:0] w_grant;
    logic [2:0] w_slot_id;
    logic [1:0] w_gate_open;

    // Derive the occupancy flags from the registered map only.
    assign w_full = &r_slot_busy;

    // Count the occupied slots.
    always_comb begin
        w_occupied = '0;
        for (int i = 0; i < c_NUM_SLOTS; i++) begin
            w_occupied = w_occupied + {2'b00, r_slot_busy[i]};
        end
    end

    // Find the lowest-index free slot. The scan runs high to low, so the
    // last hit is the lowest index.
    always_comb begin
        w_free_idx = '0;
        for (int i = c_NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_slot_busy[i]) begin
                w_free_idx = 3'(i);
            end
        end
    end

    // Choose the gate: a lone requester wins; on contention the priority
    // pointer decides.
    always_comb begin
        w_winner = 1'b0;
        case (bus.req)
            2'b01:   w_winner = 1'b0;
            2'b10:   w_winner = 1'b1;
            2'b11:   w_winner = r_prio;
            default: w_winner = 1'b0;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && (bus.req != 2'b00) && !w_full;

    // Build the next occupancy map. A release only clears a set bit. An
    // allocation is OR-ed in last, so it wins a same-bit collision.
    always_comb begin
        w_rel_mask   = '0;
        w_alloc_mask = '0;
        if (bus.release_valid && (bus.release_id < 3'd5)) begin
            w_rel_mask = 5'b00001 << bus.release_id;
        end
        if (w_start) begin
            w_alloc_mask = 5'b00001 << w_free_idx;
        end
        w_busy_next = (r_slot_busy & ~w_rel_mask) | w_alloc_mask;
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and gate outputs. Every output stays zero outside
    // GRANT/OPEN.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 2'b00;
        w_slot_id    = 3'd0;
        w_gate_open  = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_grant      = {r_winner, ~r_winner};
                w_slot_id    = r_slot_id;
                w_state_next = ST_OPEN;
            end
            ST_OPEN: begin
                w_gate_open = {r_winner, ~r_winner};
                if (r_open_cnt == 8'd0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Occupancy map register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_busy <= '0;
        end else begin
            r_slot_busy <= w_busy_next;
        end
    end

    // Capture the transaction winner and slot. Hand contention priority to
    // the other gate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_winner  <= 1'b0;
            r_slot_id <= 3'd0;
            r_prio    <= 1'b0;
        end else if (w_start) begin
            r_winner  <= w_winner;
            r_slot_id <= w_free_idx;
            r_prio    <= ~w_winner;
        end
    end

    // Open-window counter. It is loaded in GRANT, so OPEN lasts exactly
    // GATE_OPEN_CYCLES cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_open_cnt <= 8'd0;
        end else if (r_state == ST_GRANT) begin
            r_open_cnt <= c_OPEN_LAST;
        end else if ((r_state == ST_OPEN) && (r_open_cnt != 8'd0)) begin
            r_open_cnt <= r_open_cnt - 8'd1;
        end
    end

    assign bus.grant     = w_grant;
    assign bus.slot_id   = w_slot_id;
    assign bus.gate_open = w_gate_open;
    assign bus.slot_busy = r_slot_busy;
    assign bus.occupied  = w_occupied;
    assign bus.full      = w_full;

endmodule
`default_nettype wire
